// File: rtl/time_preset_loader.sv
// rtl/time_preset_loader.sv - BCD time preset register with one-hot player load sequencer
//
// Holds an editable BCD time preset while the game is stopped and, on a
// load request, strobes the preset into each player's countdown timer in turn.
//
// Optional feature macro: TIME_PRESET_MMSS_EN (mm:ss preset, digits 1 and 3 max 5).
//
// Ports:
//   CLK       clock, rising edge
//   CLR       synchronous active-high reset
//   CE        command-sampling enable
//   STOP      game stopped; editing/loading allowed only when 1
//   IMPULSE   load request, rising-edge qualified on CE cycles
//   SEL_NEXT  advance edit cursor
//   INC       increment digit under cursor
//   DIN_WE    write DIN into edit register
//   DIN       direct preset value (BCD)
//   O_D       preset value, nonzero only during a load strobe
//   O_LOAD    one-hot load strobe, one bit per player
//   O_CURSOR  selected digit index
//   O_PRESET  edit register contents
//   BUSY      load sequence running
module time_preset_loader #(
  parameter int                  DIGITS         = 4,
  parameter int                  PLAYERS        = 2,
  parameter logic [4*DIGITS-1:0] DEFAULT_PRESET = 16'h0500,
  localparam int                 CW             = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  STOP,
  input  logic                  IMPULSE,
  input  logic                  SEL_NEXT,
  input  logic                  INC,
  input  logic                  DIN_WE,
  input  logic [4*DIGITS-1:0]   DIN,
  output logic [4*DIGITS-1:0]   O_D,
  output logic [PLAYERS-1:0]    O_LOAD,
  output logic [CW-1:0]         O_CURSOR,
  output logic [4*DIGITS-1:0]   O_PRESET,
  output logic                  BUSY
);

`ifdef TIME_PRESET_MMSS_EN
  localparam bit MMSS = 1'b1;
`else
  localparam bit MMSS = 1'b0;
`endif

  localparam int CHW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state;
  logic [CHW-1:0]        ch;
  logic [4*DIGITS-1:0]   preset;
  logic [CW-1:0]         cursor;
  logic                  imp_prev;
  logic [4*DIGITS-1:0]   inc_preset;
  logic [4*DIGITS-1:0]   din_clamped;

  // In mm:ss mode the tens-of-seconds and tens-of-minutes digits stop at 5.
  function automatic logic [3:0] digit_max(input int i);
    return (MMSS && (i == 1 || i == 3)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [4*DIGITS-1:0] clamp_digits(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > digit_max(i))
        r[4*i +: 4] = digit_max(i);
    end
    return r;
  endfunction

  // Only the digit under the cursor changes; >= guards wrap even if a digit
  // were somehow above its maximum.
  always_comb begin
    inc_preset = preset;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == cursor) begin
        inc_preset[4*i +: 4] = (preset[4*i +: 4] >= digit_max(i)) ? 4'd0
                                                                  : preset[4*i +: 4] + 4'd1;
      end
    end
  end

  assign din_clamped = clamp_digits(DIN);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      ch       <= '0;
      preset   <= clamp_digits(DEFAULT_PRESET);
      cursor   <= '0;
      imp_prev <= 1'b1;  // an IMPULSE held through reset must not load
      O_LOAD   <= '0;
      O_D      <= '0;
      BUSY     <= 1'b0;
    end else begin
      // Previous-sample flag tracks every CE cycle, regardless of STOP or state.
      if (CE)
        imp_prev <= IMPULSE;

      case (state)
        IDLE: begin
          if (CE && STOP) begin
            if (IMPULSE && !imp_prev) begin
              // Channel 0 strobe is issued on the accepting edge itself.
              state  <= LOAD;
              ch     <= '0;
              O_LOAD <= PLAYERS'(1);
              O_D    <= preset;
              BUSY   <= 1'b1;
            end else if (DIN_WE) begin
              preset <= din_clamped;
            end else if (INC) begin
              preset <= inc_preset;
            end else if (SEL_NEXT) begin
              cursor <= (cursor == CW'(DIGITS-1)) ? '0 : cursor + CW'(1);
            end
          end
        end

        LOAD: begin
          // STOP abort ignores CE; remaining channels are skipped.
          if (!STOP || ch == CHW'(PLAYERS-1)) begin
            state  <= IDLE;
            ch     <= '0;
            O_LOAD <= '0;
            O_D    <= '0;
            BUSY   <= 1'b0;
          end else begin
            ch     <= ch + CHW'(1);
            O_LOAD <= PLAYERS'(1) << (ch + CHW'(1));
            O_D    <= preset;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign O_PRESET = preset;
  assign O_CURSOR = cursor;

endmodule

// File: tb/tb_time_preset_loader.sv
// tb/tb_time_preset_loader.sv - randomized self-checking bench for time_preset_loader
module tb_time_preset_loader;

  localparam int DIGITS  = 4;
  localparam int PLAYERS = 4;

`ifdef TIME_PRESET_MMSS_EN
  localparam bit MMSS = 1'b1;
`else
  localparam bit MMSS = 1'b0;
`endif

  logic                clk;
  logic                clr;
  logic                ce;
  logic                stop;
  logic                impulse;
  logic                sel_next;
  logic                inc;
  logic                din_we;
  logic [4*DIGITS-1:0] din;
  logic [4*DIGITS-1:0] o_d;
  logic [PLAYERS-1:0]  o_load;
  logic [1:0]          o_cursor;
  logic [4*DIGITS-1:0] o_preset;
  logic                busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int dg[DIGITS];
  int cursor_m;
  bit prev_m;
  int exp_ch;      // channel being strobed after the last edge, -1 if none
  int pend_q[$];   // channels still to be strobed

  time_preset_loader #(
    .DIGITS (DIGITS),
    .PLAYERS(PLAYERS)
  ) dut (
    .CLK     (clk),
    .CLR     (clr),
    .CE      (ce),
    .STOP    (stop),
    .IMPULSE (impulse),
    .SEL_NEXT(sel_next),
    .INC     (inc),
    .DIN_WE  (din_we),
    .DIN     (din),
    .O_D     (o_d),
    .O_LOAD  (o_load),
    .O_CURSOR(o_cursor),
    .O_PRESET(o_preset),
    .BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dmax(input int i);
    return (MMSS && (i == 1 || i == 3)) ? 5 : 9;
  endfunction

  function automatic int preset_val();
    int v = 0;
    for (int i = 0; i < DIGITS; i++) v += dg[i] * (1 << (4*i));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nib;
    if (clr) begin
      dg[0] = 0; dg[1] = 0; dg[2] = 5; dg[3] = 0;  // 05:00
      cursor_m = 0;
      prev_m   = 1'b1;
      exp_ch   = -1;
      pend_q.delete();
    end else begin
      if (exp_ch >= 0) begin
        if (!stop || pend_q.size() == 0) begin
          exp_ch = -1;
          pend_q.delete();
        end else begin
          exp_ch = pend_q.pop_front();
        end
      end else if (ce && stop) begin
        if (impulse && !prev_m) begin
          exp_ch = 0;
          for (int c = 1; c < PLAYERS; c++) pend_q.push_back(c);
        end else if (din_we) begin
          for (int i = 0; i < DIGITS; i++) begin
            nib = int'((din >> (4*i)) & 16'hF);
            dg[i] = (nib > dmax(i)) ? dmax(i) : nib;
          end
        end else if (inc) begin
          dg[cursor_m] = (dg[cursor_m] + 1) % (dmax(cursor_m) + 1);
        end else if (sel_next) begin
          cursor_m = (cursor_m + 1) % DIGITS;
        end
      end
      if (ce) prev_m = impulse;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("o_load",   32'(o_load),   (exp_ch >= 0) ? (32'd1 << exp_ch) : 32'd0);
    chk("o_d",      32'(o_d),      (exp_ch >= 0) ? 32'(preset_val()) : 32'd0);
    chk("busy",     32'(busy),     (exp_ch >= 0) ? 32'd1 : 32'd0);
    chk("o_cursor", 32'(o_cursor), 32'(cursor_m));
    chk("o_preset", 32'(o_preset), 32'(preset_val()));
  endtask

  task automatic idle_inputs();
    clr = 0; ce = 1; stop = 1; impulse = 0; sel_next = 0; inc = 0; din_we = 0; din = '0;
  endtask

  initial begin
    idle_inputs();

    // Reset with IMPULSE held high, then release: no load.
    clr = 1; impulse = 1;
    step();
    step();
    clr = 0;
    step();
    chk("rst_preset", 32'(o_preset), 32'h0500);
    chk("rst_noload", 32'(o_load), 32'd0);
    step();

    // Load on an IMPULSE rising edge, then hold high.
    impulse = 0;
    step();
    impulse = 1;
    step();
    chk("first_strobe", 32'(o_load), 32'h1);
    chk("first_d", 32'(o_d), 32'h0500);
    repeat (6) step();
    impulse = 0;
    step();

    // Cursor to digit 1, increment through a full wrap.
    sel_next = 1;
    step();
    sel_next = 0;
    inc = 1;
    repeat (MMSS ? 6 : 10) step();
    inc = 0;
    chk("inc_wrap", 32'(o_preset[7:4]), 32'd0);
    chk("cursor1", 32'(o_cursor), 32'd1);

    // Direct write with clamping.
    din = 16'hC7F3; din_we = 1;
    step();
    din_we = 0;
    chk("clamp", 32'(o_preset), MMSS ? 32'h5753 : 32'h9793);

    // Abort during the channel 1 strobe.
    step();
    impulse = 1;
    step();
    step();
    chk("abort_pre", 32'(o_load), 32'h2);
    stop = 0;
    step();
    chk("abort_load", 32'(o_load), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    stop = 1;
    repeat (4) step();

    // STOP=0 gating.
    impulse = 0; stop = 0;
    step();
    impulse = 1;
    step();
    impulse = 0; inc = 1;
    step();
    inc = 0; din_we = 1; din = 16'h1234;
    step();
    din_we = 0;
    step();

    // CE=0 gating with STOP=1.
    stop = 1; ce = 0; impulse = 1; inc = 1;
    step();
    inc = 0; din_we = 1; din = 16'h4321;
    step();
    din_we = 0; sel_next = 1;
    step();
    idle_inputs();
    repeat (6) step();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      clr      = ($urandom_range(99) < 2);
      ce       = ($urandom_range(99) < 80);
      stop     = ($urandom_range(99) < 88);
      if ($urandom_range(99) < 30) impulse = ~impulse;
      din_we   = ($urandom_range(99) < 10);
      inc      = ($urandom_range(99) < 30);
      sel_next = ($urandom_range(99) < 20);
      din      = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
